// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-driven enable generator for one downstream clock-gating cell.
// Latency: quiesce request 1 edge after the IdleCycles-th idle cycle; gate/ungate 1 edge after ack/wake; ready WakeCycles edges after ungate.
// Backpressure: level handshake; the domain holds quiesce_ack_i until quiesce_req_o falls; wake or cfg drop aborts a quiesce.
//
// Ports:
//   clk_i, rst_i                 ungated source clock, async active-high reset
//   cfg_enable_i                 gating permitted (0 forces and holds ACTIVE)
//   busy_i, wake_req_i           domain activity / clock request
//   quiesce_ack_i                domain drained, may be gated
//   test_en_i                    DFT override, forces clk_en_o high
//   clk_en_o, ready_o            gate enable / clock running and settled
//   quiesce_req_o, state_o       drain request / ACTIVE=0 QUIESCE=1 GATED=2 WAKE=3
module clk_gate_ctrl #(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2,
  parameter int CntWidth   = $clog2(((IdleCycles > WakeCycles) ? IdleCycles : WakeCycles) + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_enable_i,
  input  logic       busy_i,
  input  logic       wake_req_i,
  input  logic       quiesce_ack_i,
  input  logic       test_en_i,
  output logic       clk_en_o,
  output logic       ready_o,
  output logic       quiesce_req_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_QUIESCE = 2'd1;
  localparam logic [1:0] ST_GATED   = 2'd2;
  localparam logic [1:0] ST_WAKE    = 2'd3;

  localparam logic [CntWidth-1:0] IDLE_LAST = CntWidth'(IdleCycles - 1);
  // WAKE is unreachable when WakeCycles==0; the clamp only keeps the constant legal.
  localparam logic [CntWidth-1:0] WAKE_LAST = CntWidth'((WakeCycles > 0) ? WakeCycles - 1 : 0);
  localparam logic [CntWidth-1:0] CNT_ONE   = CntWidth'(1);

  if (IdleCycles < 1) begin : g_bad_idle
    $error("clk_gate_ctrl: IdleCycles must be >= 1");
  end

  logic [1:0]          r_state;
  logic [CntWidth-1:0] r_cnt;
  logic                r_gate_off;
  logic                r_ready;
  logic                r_qreq;

  logic [1:0]          w_state_nxt;
  logic [CntWidth-1:0] w_cnt_nxt;
  logic                w_idle;

  assign w_idle = ~busy_i & ~wake_req_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_ACTIVE: begin
        if (w_idle && cfg_enable_i) begin
          if (r_cnt == IDLE_LAST) begin
            w_state_nxt = ST_QUIESCE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
      end
      ST_QUIESCE: begin
        // Abort outranks an ack landing in the same cycle.
        if (wake_req_i || !cfg_enable_i) begin
          w_state_nxt = ST_ACTIVE;
        end else if (quiesce_ack_i) begin
          w_state_nxt = ST_GATED;
        end
      end
      ST_GATED: begin
        if (wake_req_i || !cfg_enable_i) begin
          w_state_nxt = (WakeCycles == 0) ? ST_ACTIVE : ST_WAKE;
        end
      end
      default: begin
        // WAKE: fixed settle time, not abortable.
        if (r_cnt == WAKE_LAST) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
    endcase
  end

  // Output decodes are registered from the next state so each output is a
  // single flop and cannot glitch while the 2-bit state changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_ACTIVE;
      r_cnt      <= '0;
      r_gate_off <= 1'b0;
      r_ready    <= 1'b1;
      r_qreq     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gate_off <= (w_state_nxt == ST_GATED);
      r_ready    <= (w_state_nxt == ST_ACTIVE);
      r_qreq     <= (w_state_nxt == ST_QUIESCE);
    end
  end

  assign clk_en_o      = ~r_gate_off | test_en_i;
  assign ready_o       = r_ready;
  assign quiesce_req_o = r_qreq;
  assign state_o       = r_state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cfg_enable_i = 1'b1;
  logic       busy_i = 1'b0;
  logic       wake_req_i = 1'b0;
  logic       quiesce_ack_i = 1'b0;
  logic       test_en_i = 1'b0;

  logic       clk_en_o, ready_o, quiesce_req_o;
  logic [1:0] state_o;
  logic       clk_en0_o, ready0_o, quiesce_req0_o;
  logic [1:0] state0_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  clk_gate_ctrl #(.IdleCycles(4), .WakeCycles(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i), .busy_i(busy_i),
    .wake_req_i(wake_req_i), .quiesce_ack_i(quiesce_ack_i), .test_en_i(test_en_i),
    .clk_en_o(clk_en_o), .ready_o(ready_o), .quiesce_req_o(quiesce_req_o), .state_o(state_o)
  );

  clk_gate_ctrl #(.IdleCycles(4), .WakeCycles(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i), .busy_i(busy_i),
    .wake_req_i(wake_req_i), .quiesce_ack_i(quiesce_ack_i), .test_en_i(test_en_i),
    .clk_en_o(clk_en0_o), .ready_o(ready0_o), .quiesce_req_o(quiesce_req0_o), .state_o(state0_o)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    cfg_enable_i = 1'b1; busy_i = 1'b0; wake_req_i = 1'b0;
    quiesce_ack_i = 1'b0; test_en_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
  endtask

  // Four idle edges from a fresh ACTIVE count reach QUIESCE.
  task automatic go_quiesce();
    cfg_enable_i = 1'b1; busy_i = 1'b0; wake_req_i = 1'b0; quiesce_ack_i = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(1);
    n_checks++;
    if ({clk_en_o, ready_o, quiesce_req_o, state_o} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_values: got en/rdy/qreq/state=%b%b%b/%0d want 110/0",
               clk_en_o, ready_o, quiesce_req_o, state_o);
    end
  endtask

  task automatic test_idle_to_quiesce();
    apply_reset();
    tick(3);
    n_checks++;
    if (quiesce_req_o !== 1'b0 || state_o !== 2'd0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_3_edges: got qreq=%b state=%0d ready=%b want 0/0/1",
               quiesce_req_o, state_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (quiesce_req_o !== 1'b1 || state_o !== 2'd1 || ready_o !== 1'b0 || clk_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_4_edges: got qreq=%b state=%0d ready=%b en=%b want 1/1/0/1",
               quiesce_req_o, state_o, ready_o, clk_en_o);
    end
  endtask

  task automatic test_busy_restart();
    apply_reset();
    tick(2);
    busy_i = 1'b1;
    tick(1);
    busy_i = 1'b0;
    quiesce_ack_i = 1'b1;   // ack outside QUIESCE must be ignored
    tick(3);
    n_checks++;
    if (state_o !== 2'd0 || quiesce_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_restart_3: got state=%0d qreq=%b want 0/0", state_o, quiesce_req_o);
    end
    quiesce_ack_i = 1'b0;
    tick(1);
    n_checks++;
    if (state_o !== 2'd1 || quiesce_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_restart_4: got state=%0d qreq=%b want 1/1", state_o, quiesce_req_o);
    end
  endtask

  task automatic test_gate_wake();
    apply_reset();
    go_quiesce();
    quiesce_ack_i = 1'b1;
    tick(1);
    n_checks++;
    if (state_o !== 2'd2 || clk_en_o !== 1'b0 || ready_o !== 1'b0 || quiesce_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_on_ack: got state=%0d en=%b rdy=%b qreq=%b want 2/0/0/0",
               state_o, clk_en_o, ready_o, quiesce_req_o);
    end
    busy_i = 1'b1;          // ignored while gated; ack still held
    tick(3);
    n_checks++;
    if (state_o !== 2'd2 || clk_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL gated_hold: got state=%0d en=%b want 2/0", state_o, clk_en_o);
    end
    busy_i = 1'b0; quiesce_ack_i = 1'b0;
    wake_req_i = 1'b1;
    tick(1);
    wake_req_i = 1'b0;
    n_checks++;
    if (state_o !== 2'd3 || clk_en_o !== 1'b1 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_enable: got state=%0d en=%b rdy=%b want 3/1/0", state_o, clk_en_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd3 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_settle1: got state=%0d rdy=%b want 3/0", state_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd0 || ready_o !== 1'b1 || clk_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_ready: got state=%0d rdy=%b en=%b want 0/1/1", state_o, ready_o, clk_en_o);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    go_quiesce();
    quiesce_ack_i = 1'b1; wake_req_i = 1'b1;
    tick(1);
    quiesce_ack_i = 1'b0; wake_req_i = 1'b0;
    n_checks++;
    if (state_o !== 2'd0 || clk_en_o !== 1'b1 || ready_o !== 1'b1 || quiesce_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wake: got state=%0d en=%b rdy=%b qreq=%b want 0/1/1/0",
               state_o, clk_en_o, ready_o, quiesce_req_o);
    end
    go_quiesce();
    quiesce_ack_i = 1'b1; cfg_enable_i = 1'b0;
    tick(1);
    quiesce_ack_i = 1'b0;
    n_checks++;
    if (state_o !== 2'd0 || clk_en_o !== 1'b1 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_cfg: got state=%0d en=%b rdy=%b want 0/1/1", state_o, clk_en_o, ready_o);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      n_checks++;
      if (state_o !== 2'd0 || clk_en_o !== 1'b1) begin
        n_fail++;
        $display("FAIL cfg_hold_active[%0d]: got state=%0d en=%b want 0/1", i, state_o, clk_en_o);
      end
    end
    cfg_enable_i = 1'b1;
  endtask

  task automatic test_wake_zero_and_cfg_drop();
    apply_reset();
    go_quiesce();
    quiesce_ack_i = 1'b1;
    tick(1);
    quiesce_ack_i = 1'b0;
    n_checks++;
    if (state0_o !== 2'd2 || clk_en0_o !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_gated: got state=%0d en=%b want 2/0", state0_o, clk_en0_o);
    end
    wake_req_i = 1'b1;
    tick(1);
    wake_req_i = 1'b0;
    n_checks++;
    if (state0_o !== 2'd0 || clk_en0_o !== 1'b1 || ready0_o !== 1'b1) begin
      n_fail++;
      $display("FAIL w0_wake_same_edge: got state=%0d en=%b rdy=%b want 0/1/1",
               state0_o, clk_en0_o, ready0_o);
    end
    // Both instances back to GATED, then drop cfg_enable.
    apply_reset();
    go_quiesce();
    quiesce_ack_i = 1'b1;
    tick(1);
    quiesce_ack_i = 1'b0;
    cfg_enable_i = 1'b0;
    tick(1);
    n_checks++;
    if (state_o !== 2'd3 || clk_en_o !== 1'b1 || state0_o !== 2'd0 || ready0_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_drop_gated: got state=%0d en=%b state0=%0d rdy0=%b want 3/1/0/1",
               state_o, clk_en_o, state0_o, ready0_o);
    end
    tick(2);
    n_checks++;
    if (state_o !== 2'd0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_drop_wake_done: got state=%0d rdy=%b want 0/1", state_o, ready_o);
    end
    cfg_enable_i = 1'b1;
  endtask

  task automatic test_dft_and_async_reset();
    apply_reset();
    go_quiesce();
    quiesce_ack_i = 1'b1;
    tick(1);
    quiesce_ack_i = 1'b0;
    test_en_i = 1'b1;
    #1;
    n_checks++;
    if (clk_en_o !== 1'b1 || state_o !== 2'd2 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL test_en_comb: got en=%b state=%0d rdy=%b want 1/2/0", clk_en_o, state_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL test_en_state: got state=%0d want 2", state_o);
    end
    test_en_i = 1'b0;
    #1;
    n_checks++;
    if (clk_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL test_en_release: got en=%b want 0", clk_en_o);
    end
    #1 rst_i = 1'b1;
    #1;
    n_checks++;
    if (clk_en_o !== 1'b1 || ready_o !== 1'b1 || state_o !== 2'd0 || quiesce_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b rdy=%b state=%0d qreq=%b want 1/1/0/0",
               clk_en_o, ready_o, state_o, quiesce_req_o);
    end
    tick(1);
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_to_quiesce();
    test_busy_restart();
    test_gate_wake();
    test_abort();
    test_wake_zero_and_cfg_drop();
    test_dft_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
